// File: rtl/multiword_add_seq_pkg.sv
// Shared constants and types for the multi-word sequential adder.
// Used by the interface, the add_slice sub-module and the multiword_add_seq top.
package multiword_add_pkg;

    localparam int W_DEFAULT     = 16;
    localparam int BEATS_DEFAULT = 4;

    // A single-beat operation still needs a one-bit counter to keep the ports legal.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(BEATS_DEFAULT);

    typedef logic [CNT_W_DEFAULT-1:0] beat_t;
    typedef logic [W_DEFAULT-1:0]     slice_t;

endpackage

// File: rtl/multiword_add_seq_if.sv
// Operand/result stream bundle for multiword_add_seq.
// Optional MULTIWORD_ADD_OVF_EN adds the out_ovf signed-overflow flag.
interface multiword_add_seq_if
    import multiword_add_pkg::*;
#(
    parameter int W = W_DEFAULT
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_last;
    logic         out_cout;
`ifdef MULTIWORD_ADD_OVF_EN
    logic         out_ovf;
`endif

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_last, out_cout
`ifdef MULTIWORD_ADD_OVF_EN
        , input out_ovf
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_last, out_cout
`ifdef MULTIWORD_ADD_OVF_EN
        , output out_ovf
`endif
    );

endinterface

// File: rtl/multiword_add_seq_add_slice.sv
// Combinational W-bit ripple-carry adder built from full-adder cells.
module add_slice
    import multiword_add_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[W];

endmodule

// File: rtl/multiword_add_seq.sv
// Wide (W*BEATS) adder processed one W-bit slice per beat, LS word first.
// Define MULTIWORD_ADD_OVF_EN to add the out_ovf signed-overflow output.
module multiword_add_seq
    import multiword_add_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int BEATS = BEATS_DEFAULT
) (
    input logic              clk,
    input logic              rst_n,
    multiword_add_seq_if.slave bus
);

    localparam int               CNT_W     = cnt_width(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0] beat;
    logic             carry_q;
    logic             valid_q;
    logic [W-1:0]     sum_q;
    logic             last_q;
    logic             cout_q;

    logic             in_xfer;
    logic             is_first;
    logic             is_last;
    logic             cin_eff;
    logic [W-1:0]     slice_sum;
    logic             slice_cout;

    assign bus.in_ready  = !valid_q || bus.out_ready;
    assign in_xfer       = bus.in_valid && bus.in_ready;
    assign is_first      = (beat == '0);
    assign is_last       = (beat == LAST_BEAT);
    // A fresh operation must never see the carry left over from the previous one.
    assign cin_eff       = is_first ? bus.in_cin : carry_q;

    assign bus.out_valid = valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_last  = last_q;
    assign bus.out_cout  = cout_q;

    add_slice #(.W(W)) u_add_slice (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .cin  (cin_eff),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat    <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else if (in_xfer) begin
            beat    <= is_last ? '0 : beat + CNT_W'(1);
            carry_q <= slice_cout;
            valid_q <= 1'b1;
            sum_q   <= slice_sum;
            last_q  <= is_last;
            cout_q  <= is_last ? slice_cout : 1'b0;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef MULTIWORD_ADD_OVF_EN
    logic ovf_q;
    logic slice_ovf;

    assign slice_ovf   = (bus.in_a[W-1] == bus.in_b[W-1]) && (slice_sum[W-1] != bus.in_a[W-1]);
    assign bus.out_ovf = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (in_xfer) begin
            ovf_q <= is_last ? slice_ovf : 1'b0;
        end
    end
`endif

endmodule
